// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature generator.
//   state_t        : generator FSM states (IDLE, first phase, second phase, finish)
//   DIR_UP/DIR_DOWN: command direction encoding (up = A leads B)
//   DEF_MIN_TICKS  : default floor on the phase hold time
//   gray_next()    : next A/B level one quadrature edge away in a given direction
package quad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PH1,
    ST_PH2,
    ST_FIN
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Must stay above the receiving debounce history length (8 samples).
  localparam int DEF_MIN_TICKS = 16;

  // Up ring (A is the MSB): 00 -> 10 -> 11 -> 01 -> 00; down walks it backwards.
  function automatic logic [1:0] gray_next(input logic [1:0] ab, input logic dir);
    case (ab)
      2'b00:   gray_next = (dir == DIR_UP) ? 2'b10 : 2'b01;
      2'b10:   gray_next = (dir == DIR_UP) ? 2'b11 : 2'b00;
      2'b11:   gray_next = (dir == DIR_UP) ? 2'b01 : 2'b10;
      default: gray_next = (dir == DIR_UP) ? 2'b00 : 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase hold timer: a down-counter that measures one quadrature phase.
//   clk, reset : system clock, asynchronous active-low reset
//   load       : start a new phase (wins over an expiry in the same cycle)
//   load_val   : hold length minus one, in clocks
//   expire     : high for the last clock of the phase; the owner switches
//                phase on the following edge
module phase_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             expire
);

  logic [DIV_W-1:0] cnt;
  logic             active;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before the edge, whatever the order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

  assign expire = active && (cnt == '0);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature generator: turns a step count and direction into A/B quadrature.
// One step (detent) is two Gray edges, each phase held T = max(phase_ticks,
// MIN_TICKS) clocks. Detent levels alternate between 00 and 11.
//   clk, reset   : system clock, asynchronous active-low reset
//   cmd_valid    : command offered; accepted when cmd_ready is high
//   cmd_ready    : generator idle
//   cmd_dir      : 1 = up (A leads B), 0 = down (B leads A)
//   cmd_steps    : detents to emit (0 completes immediately)
//   phase_ticks  : clocks per phase, sampled on accept
//   abort        : level, looked at only when a step completes
//   enc_a, enc_b : registered quadrature outputs
//   busy         : command in progress
//   done         : one-cycle pulse at command end
//   position     : net detents emitted, wraps
module quad_encoder_gen
  import quad_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DIV_W     = 16,
  parameter int MIN_TICKS = DEF_MIN_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] phase_ticks,
  input  logic             abort,
  output logic             enc_a,
  output logic             enc_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] position
);

  state_t           state;
  logic             dir_q;
  logic [CNT_W-1:0] remaining;   // includes the step currently being emitted
  logic [DIV_W-1:0] hold_ticks;

  logic             accept;
  logic             step_end;
  logic             more_steps;
  logic             timer_load;
  logic             expire;
  logic [DIV_W-1:0] req_ticks;
  logic [DIV_W-1:0] timer_val;

  assign cmd_ready = (state == ST_IDLE);

  // NOTE: every signal gets a default at the top of the block; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    accept     = 1'b0;
    step_end   = 1'b0;
    more_steps = 1'b0;
    timer_load = 1'b0;
    req_ticks  = phase_ticks;
    timer_val  = '0;

    accept   = cmd_valid && (state == ST_IDLE);
    if (phase_ticks < DIV_W'(MIN_TICKS)) req_ticks = DIV_W'(MIN_TICKS);
    step_end   = (state == ST_PH2) && expire;
    more_steps = (remaining != CNT_W'(1)) && !abort;
    // The timer restarts on every emitted edge: the first edge of a command,
    // the mid-step edge, and the first edge of each following step.
    timer_load = (accept && (cmd_steps != '0)) ||
                 ((state == ST_PH1) && expire) ||
                 (step_end && more_steps);
    // On accept the stored hold is not yet valid, so take the fresh value.
    timer_val  = ((state == ST_IDLE) ? req_ticks : hold_ticks) - 1'b1;
  end

  phase_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      dir_q      <= DIR_DOWN;
      remaining  <= '0;
      hold_ticks <= '0;
      enc_a      <= 1'b0;
      enc_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      position   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dir_q      <= cmd_dir;
            hold_ticks <= req_ticks;
            remaining  <= cmd_steps;
            if (cmd_steps == '0) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state          <= ST_PH1;
              busy           <= 1'b1;
              {enc_a, enc_b} <= gray_next({enc_a, enc_b}, cmd_dir);
            end
          end
        end
        ST_PH1: begin
          if (expire) begin
            state          <= ST_PH2;
            {enc_a, enc_b} <= gray_next({enc_a, enc_b}, dir_q);
          end
        end
        ST_PH2: begin
          if (expire) begin
            position  <= (dir_q == DIR_UP) ? position + 1'b1 : position - 1'b1;
            remaining <= remaining - 1'b1;
            if (more_steps) begin
              state          <= ST_PH1;
              {enc_a, enc_b} <= gray_next({enc_a, enc_b}, dir_q);
            end else begin
              state <= ST_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen. A time-based model predicts every
// output from the elapsed clocks since accept; a quadrature decoder rebuilds
// the position from enc_a/enc_b and is compared with position after each done.
module tb_quad_encoder_gen;

  localparam int MIN_T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [7:0]  cmd_steps;
  logic [15:0] phase_ticks;
  logic        abort;
  logic        enc_a;
  logic        enc_b;
  logic        busy;
  logic        done;
  logic [7:0]  position;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quad_encoder_gen #(.CNT_W(8), .DIV_W(16), .MIN_TICKS(MIN_T)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_dir     (cmd_dir),
    .cmd_steps   (cmd_steps),
    .phase_ticks (phase_ticks),
    .abort       (abort),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .busy        (busy),
    .done        (done),
    .position    (position)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Quadrature index: position of an A/B level on the up ring 00,10,11,01.
  function automatic logic [1:0] gray_of(input logic [1:0] idx);
    case (idx)
      2'd0:    gray_of = 2'b00;
      2'd1:    gray_of = 2'b10;
      2'd2:    gray_of = 2'b11;
      default: gray_of = 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] idx_of(input logic [1:0] ab);
    case (ab)
      2'b00:   idx_of = 2'd0;
      2'b10:   idx_of = 2'd1;
      2'b11:   idx_of = 2'd2;
      default: idx_of = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] step_idx(input logic [1:0] base, input logic dir, input int m);
    int v;
    v = dir ? int'(base) + m : int'(base) - m;
    return v[1:0];
  endfunction

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_FIN} mmode_t;
  mmode_t     m_mode;
  logic [1:0] m_idx, m_base;
  logic       m_dir;
  int         m_n, m_t, m_k;
  logic [7:0] m_pos;
  int         edge_n;

  task automatic model_step();
    int j;
    case (m_mode)
      M_IDLE: begin
        if (cmd_valid === 1'b1) begin
          m_dir  = cmd_dir;
          m_n    = int'(cmd_steps);
          m_t    = (int'(phase_ticks) < MIN_T) ? MIN_T : int'(phase_ticks);
          m_base = m_idx;
          m_k    = 0;
          if (m_n == 0) m_mode = M_FIN;
          else begin
            m_mode = M_RUN;
            m_idx  = step_idx(m_base, m_dir, 1);
          end
        end
      end
      M_RUN: begin
        m_k++;
        if (m_k % (2 * m_t) == 0) begin
          j     = m_k / (2 * m_t);
          m_pos = m_dir ? m_pos + 8'd1 : m_pos - 8'd1;
          if (j == m_n || abort === 1'b1) begin
            m_mode = M_FIN;
            m_idx  = step_idx(m_base, m_dir, 2 * j);
          end else begin
            m_idx = step_idx(m_base, m_dir, m_k / m_t + 1);
          end
        end else begin
          m_idx = step_idx(m_base, m_dir, m_k / m_t + 1);
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  initial begin
    edge_n = 0;
    m_mode = M_IDLE;
    m_idx  = 2'd0;
    m_base = 2'd0;
    m_dir  = 1'b0;
    m_n    = 0;
    m_t    = MIN_T;
    m_k    = 0;
    m_pos  = 8'd0;
    forever begin
      @(posedge clk or negedge reset);
      if (reset !== 1'b1) begin
        m_mode = M_IDLE;
        m_idx  = 2'd0;
        m_pos  = 8'd0;
      end else begin
        edge_n++;
        model_step();
      end
    end
  end

  // ---------------- compare process + loop-back decoder ----------------
  int         dec_phases = 0;
  logic [1:0] prev_ab    = 2'b00;
  int         done_edge  = -1;

  function automatic int dec8();
    int h;
    h = dec_phases / 2;
    return int'(h[7:0]);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      check("enc_ab",    int'({enc_a, enc_b}), int'(gray_of(m_idx)));
      check("busy",      int'(busy),      int'(m_mode == M_RUN));
      check("done",      int'(done),      int'(m_mode == M_FIN));
      check("cmd_ready", int'(cmd_ready), int'(m_mode == M_IDLE));
      check("position",  int'(position),  int'(m_pos));
      if (reset !== 1'b1) begin
        dec_phases = 0;
        prev_ab    = 2'b00;
      end else if ({enc_a, enc_b} != prev_ab) begin
        logic [1:0] d;
        check("single_bit_edge", $countones({enc_a, enc_b} ^ prev_ab), 1);
        d = idx_of({enc_a, enc_b}) - idx_of(prev_ab);
        if (d == 2'd1)      dec_phases++;
        else if (d == 2'd3) dec_phases--;
        prev_ab = {enc_a, enc_b};
      end
      if (done === 1'b1) done_edge = edge_n;
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic dir, input logic [7:0] steps, input logic [15:0] ticks,
                      input bit keep, output int acc);
    cmd_dir     = dir;
    cmd_steps   = steps;
    phase_ticks = ticks;
    cmd_valid   = 1'b1;
    acc         = -1;
    for (int i = 0; i < 5000; i++) begin
      if (cmd_ready === 1'b1) begin
        @(posedge clk);
        #1;
        acc = edge_n;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) check("accept_timeout", 0, 1);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_abort, output int d);
    d = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rand_abort) abort = ($urandom_range(0, 7) == 0);
      if (done === 1'b1) begin
        d = edge_n;
        break;
      end
    end
    if (d < 0) check("done_timeout", 0, 1);
    else       check("decoded_vs_position", dec8(), int'(position));
    if (rand_abort) abort = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, acc2, d;
    logic [1:0] ab_before;
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_dir     = 1'b0;
    cmd_steps   = 8'd0;
    phase_ticks = 16'd0;
    abort       = 1'b0;
    #2;
    check("reset_ab",       int'({enc_a, enc_b}), 0);
    check("reset_ready",    int'(cmd_ready), 1);
    check("reset_position", int'(position), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: up 5 steps, T=20
    send(1'b1, 8'd5, 16'd20, 1'b0, acc);
    check("t1_first_edge", int'({enc_a, enc_b}), 2'b10);
    wait_done(1000, 1'b0, d);
    check("t1_latency",  d - acc, 200);
    check("t1_position", int'(position), 5);
    check("t1_decoded",  dec8(), 5);
    check("t1_detent",   int'({enc_a, enc_b}), 2'b11);

    // 2: down 3 steps from 0, T clamps to 16
    apply_reset();
    send(1'b0, 8'd3, 16'd4, 1'b0, acc);
    check("t2_first_edge", int'({enc_a, enc_b}), 2'b01);
    wait_done(1000, 1'b0, d);
    check("t2_latency",  d - acc, 96);
    check("t2_position", int'(position), 8'hFD);
    check("t2_decoded",  dec8(), 253);

    // 3: zero steps
    ab_before = {enc_a, enc_b};
    send(1'b1, 8'd0, 16'd30, 1'b0, acc);
    check("t3_done_now", int'(done), 1);
    check("t3_no_edge",  int'({enc_a, enc_b}), int'(ab_before));
    wait_done(10, 1'b0, d);
    check("t3_latency",  d - acc, 0);
    check("t3_done_gone", int'(done), 0);
    check("t3_no_edge_after", int'({enc_a, enc_b}), int'(ab_before));
    check("t3_position", int'(position), 8'hFD);

    // 5: async reset during step 2 PH2
    send(1'b1, 8'd5, 16'd16, 1'b0, acc);
    while (edge_n < acc + 55) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("t5_ab",       int'({enc_a, enc_b}), 0);
    check("t5_busy",     int'(busy), 0);
    check("t5_position", int'(position), 0);
    check("t5_ready",    int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // 4: up 10 steps, abort raised in step 3 PH1 and held until done
    send(1'b1, 8'd10, 16'd16, 1'b0, acc);
    check("t4_accept_after_reset", int'(busy), 1);
    while (edge_n < acc + 66) @(posedge clk);
    #1 abort = 1'b1;
    wait_done(1000, 1'b0, d);
    abort = 1'b0;
    check("t4_latency",  d - acc, 96);
    check("t4_position", int'(position), 3);
    check("t4_detent",   int'({enc_a, enc_b}), 2'b11);

    // 6: back-to-back with cmd_valid held; phase_ticks changed while busy
    send(1'b0, 8'd2, 16'd16, 1'b1, acc);
    send(1'b1, 8'd1, 16'd18, 1'b0, acc2);
    check("t6_gap", acc2 - done_edge, 2);
    phase_ticks = 16'd100;
    wait_done(1000, 1'b0, d);
    check("t6_latency",  d - acc2, 36);
    check("t6_position", int'(position), 2);

    // random commands, random abort levels, occasional back-to-back
    for (int i = 0; i < 30; i++) begin
      logic       r_dir;
      logic [7:0] r_steps;
      logic [15:0] r_ticks;
      bit         r_keep;
      r_dir   = 1'($urandom_range(0, 1));
      r_steps = 8'($urandom_range(0, 5));
      r_ticks = 16'($urandom_range(0, 24));
      r_keep  = (i < 29) && ($urandom_range(0, 2) == 0);
      send(r_dir, r_steps, r_ticks, r_keep, acc);
      wait_done(1000, 1'b1, d);
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
